osd_text_overlay_mc: RTL

Multi-channel successor to the single-region OSD character overlay. It takes a VESA-timed RGB565 stream and overlays up to N_CH vertically stacked text regions, one per video channel. Glyph bitmaps are read from the external UDP receive RAM, one bit per pixel, MSB = leftmost pixel. It sits between the video mux and the HDMI output, in the video clock domain.

---
 rtl/osd_pkg.sv | 29 ++
 rtl/osd_pos_counter.sv | 41 ++++
 rtl/osd_text_overlay_mc.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/osd_pkg.sv
// Shared constants and helpers for the multi-channel OSD text overlay:
// RGB565 field layout, pipeline latency, counter width, region sizing.
package osd_pkg;

   localparam int CNT_W   = 12;
   localparam int LATENCY = 3;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   function automatic int region_bytes(input int reg_w, input int reg_h);
      return (reg_w / 8) * reg_h;
   endfunction

   // Halves each colour field independently so no bits leak between fields.
   function automatic logic [15:0] dim565(input logic [15:0] pix);
      logic [15:0] res;
      res = 16'h0000;
      res[R_MSB:R_LSB] = {1'b0, pix[R_MSB:R_LSB+1]};
      res[G_MSB:G_LSB] = {1'b0, pix[G_MSB:G_LSB+1]};
      res[B_MSB:B_LSB] = {1'b0, pix[B_MSB:B_LSB+1]};
      return res;
   endfunction

endpackage

// File: rtl/osd_pos_counter.sv
// Pixel/line position counters for the OSD overlay: x counts active pixels
// within a line, y counts lines since the last vsync rising edge.
module osd_pos_counter
   import osd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vs,
   input  logic             de,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             vs_rise
);

   logic vs_d;
   logic de_d;

   assign vs_rise = vs & ~vs_d;

   // Edge history and position counters; vsync rise takes priority over a line end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vs_d <= 1'b0;
         de_d <= 1'b0;
         x    <= '0;
         y    <= '0;
      end else begin
         vs_d <= vs;
         de_d <= de;
         x    <= de ? x + CNT_W'(1) : '0;
         if (vs_rise) begin
            y <= '0;
         end else if (de_d && !de) begin
            y <= y + CNT_W'(1);
         end else begin
            y <= y;
         end
      end
   end

endmodule

// File: rtl/osd_text_overlay_mc.sv
// Overlays up to N_CH vertically stacked 1bpp text regions on an RGB565 stream,
// fixed 3-cycle latency. Define OSD_BG_DIM_EN to dim non-glyph pixels in a region.
module osd_text_overlay_mc
   import osd_pkg::*;
#(
   parameter int                N_CH       = 4,
   parameter int                DATA_W     = 16,
   parameter int                ADDR_W     = 11,
   parameter int                REG_W      = 64,
   parameter int                REG_H      = 16,
   parameter int                X_START    = 1000,
   parameter int                Y_START    = 270,
   parameter int                Y_INTERVAL = 90,
   parameter logic [DATA_W-1:0] COLOR_CHAR = 16'hFFFF,
   parameter logic [DATA_W-1:0] COLOR_SEL  = 16'hFFE0
) (
   input  logic              video_clk,
   input  logic              rst_n,
   input  logic              i_hs,
   input  logic              i_vs,
   input  logic              i_de,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_hs,
   output logic              o_vs,
   output logic              o_de,
   output logic [DATA_W-1:0] o_data,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_rdata,
   input  logic              udp_rec_data_valid,
   input  logic [N_CH-1:0]   ch_en,
   input  logic [2:0]        ch_sel
);

   localparam int BPR = REG_W / 8;
   localparam int RB  = region_bytes(REG_W, REG_H);

   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] y;
   logic             vs_rise;

   logic             frame_valid;
   logic [N_CH-1:0]  ch_en_q;
   logic [2:0]       ch_sel_q;

   int               col_s;
   int               row_s;
   int               k_s;
   logic             hit_s;
   logic             x_in_s;
   logic [ADDR_W-1:0] addr_s;
   logic [2:0]       bit_s;
   logic             sel_s;

   logic [LATENCY-1:0] hs_sr;
   logic [LATENCY-1:0] vs_sr;
   logic [LATENCY-1:0] de_sr;

   logic              s1_hit, s2_hit;
   logic [2:0]        s1_bit, s2_bit;
   logic              s1_sel, s2_sel;
   logic [DATA_W-1:0] s1_data, s2_data;

   logic              glyph_s;
   logic [DATA_W-1:0] pix_s;

   osd_pos_counter u_pos (
      .clk     (video_clk),
      .rst_n   (rst_n),
      .vs      (i_vs),
      .de      (i_de),
      .x       (x),
      .y       (y),
      .vs_rise (vs_rise)
   );

   // Per-frame configuration, latched only at vsync rise to avoid tearing.
   always_ff @(posedge video_clk) begin
      if (!rst_n) begin
         frame_valid <= 1'b0;
         ch_en_q     <= '0;
         ch_sel_q    <= 3'd0;
      end else if (vs_rise) begin
         frame_valid <= udp_rec_data_valid;
         ch_en_q     <= ch_en;
         ch_sel_q    <= ch_sel;
      end else begin
         frame_valid <= frame_valid;
      end
   end

   // Region hit and glyph address; descending scan lets the lowest region win.
   always_comb begin
      col_s  = int'(x) - X_START;
      x_in_s = (col_s >= 0) && (col_s < REG_W);
      hit_s  = 1'b0;
      k_s    = 0;
      row_s  = 0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (frame_valid && i_de && ch_en_q[k] && x_in_s &&
             (int'(y) >= Y_START + k * Y_INTERVAL) &&
             (int'(y) <  Y_START + k * Y_INTERVAL + REG_H)) begin
            hit_s = 1'b1;
            k_s   = k;
            row_s = int'(y) - (Y_START + k * Y_INTERVAL);
         end else begin
            hit_s = hit_s;
         end
      end
      addr_s = ADDR_W'(k_s * RB + row_s * BPR + col_s / 8);
      bit_s  = 3'(col_s);
      sel_s  = (k_s == int'(ch_sel_q));
   end

   // Stages 1 and 2; ram_addr only moves on a hit so the RAM sees a stable address otherwise.
   always_ff @(posedge video_clk) begin
      if (!rst_n) begin
         ram_addr <= '0;
         hs_sr    <= '0;
         vs_sr    <= '0;
         de_sr    <= '0;
         s1_hit   <= 1'b0;
         s1_bit   <= 3'd0;
         s1_sel   <= 1'b0;
         s1_data  <= '0;
         s2_hit   <= 1'b0;
         s2_bit   <= 3'd0;
         s2_sel   <= 1'b0;
         s2_data  <= '0;
      end else begin
         if (hit_s) begin
            ram_addr <= addr_s;
         end
         hs_sr   <= {hs_sr[LATENCY-2:0], i_hs};
         vs_sr   <= {vs_sr[LATENCY-2:0], i_vs};
         de_sr   <= {de_sr[LATENCY-2:0], i_de};
         s1_hit  <= hit_s;
         s1_bit  <= bit_s;
         s1_sel  <= sel_s;
         s1_data <= i_data;
         s2_hit  <= s1_hit;
         s2_bit  <= s1_bit;
         s2_sel  <= s1_sel;
         s2_data <= s1_data;
      end
   end

   // Pixel selection from the glyph byte returned for the stage-1 address.
   always_comb begin
      glyph_s = ram_rdata[3'd7 - s2_bit];
      if (s2_hit && glyph_s) begin
         pix_s = s2_sel ? COLOR_SEL : COLOR_CHAR;
      end else if (s2_hit) begin
`ifdef OSD_BG_DIM_EN
         pix_s = dim565(s2_data);
`else
         pix_s = s2_data;
`endif
      end else begin
         pix_s = s2_data;
      end
   end

   // Output pixel register (stage 3).
   always_ff @(posedge video_clk) begin
      if (!rst_n) begin
         o_data <= '0;
      end else begin
         o_data <= pix_s;
      end
   end

   assign o_hs = hs_sr[LATENCY-1];
   assign o_vs = vs_sr[LATENCY-1];
   assign o_de = de_sr[LATENCY-1];

endmodule
